// File: rtl/shape_processor_ctrl_writer.sv
// Bus initiator that programs the shape processor CTRL SFR (SHAPE[17:16], OPERATION[5:0]).
// It resolves KEEP fields against a local shadow, pre-checks legality, writes, then reads back to classify.
module shape_processor_ctrl_writer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = 8'h00,
  parameter int                TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_shape,
  input  logic [5:0]        req_operation,
  output logic              bus_write,
  output logic              bus_read,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_code,
  output logic [1:0]        cur_shape,
  output logic [5:0]        cur_operation
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_RESP} state_t;
  typedef enum logic [1:0] {RC_OK, RC_LOCAL_REJECT, RC_HW_REJECT, RC_ERROR} resp_t;

  localparam int          CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       shadow_shape, old_shape, eff_shape_q;
  logic [5:0]       shadow_op, old_op, eff_op_q;
  logic [1:0]       eff_shape, rb_shape;
  logic [5:0]       eff_op, rb_op;
  logic             op_known, local_reject, timed_out;
  logic             unused_rdata;

  function automatic logic pair_legal(input logic [1:0] s, input logic [5:0] o);
    case (o)
      6'h00, 6'h01: return (s == 2'b01) || (s == 2'b10);
      6'h10:        return (s == 2'b01);
      6'h20, 6'h21: return (s == 2'b10);
      default:      return 1'b0;
    endcase
  endfunction

  assign req_ready     = (state == S_IDLE);
  assign bus_addr      = CTRL_ADDR;
  assign cur_shape     = shadow_shape;
  assign cur_operation = shadow_op;
  assign rb_shape      = bus_rdata[17:16];
  assign rb_op         = bus_rdata[5:0];
  assign unused_rdata  = ^{bus_rdata[31:18], bus_rdata[15:6]};
  assign timed_out     = (cnt == CNT_MAX);

  always_comb begin
    eff_shape    = (req_shape == 2'b11) ? shadow_shape : req_shape;
    eff_op       = (req_operation == 6'h3F) ? shadow_op : req_operation;
    op_known     = (req_operation inside {6'h00, 6'h01, 6'h10, 6'h20, 6'h21, 6'h3F});
    local_reject = (req_shape == 2'b00) || !op_known || !pair_legal(eff_shape, eff_op);
  end

  // NOTE: every register here is assigned with <= so all of them sample the same pre-edge values;
  // NOTE: the async reset clears the whole state, so an access in flight is abandoned instantly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      cnt          <= '0;
      bus_write    <= 1'b0;
      bus_read     <= 1'b0;
      bus_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_code    <= RC_OK;
      shadow_shape <= '0;
      shadow_op    <= '0;
      old_shape    <= '0;
      old_op       <= '0;
      eff_shape_q  <= '0;
      eff_op_q     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          // First cycle out of reset starts the read; a timeout leaves the shadow at zero.
          if (!bus_read) begin
            bus_read <= 1'b1;
            cnt      <= '0;
          end else if (bus_ready) begin
            shadow_shape <= rb_shape;
            shadow_op    <= rb_op;
            bus_read     <= 1'b0;
            state        <= S_IDLE;
          end else if (timed_out) begin
            bus_read <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            eff_shape_q <= eff_shape;
            eff_op_q    <= eff_op;
            old_shape   <= shadow_shape;
            old_op      <= shadow_op;
            if (local_reject) begin
              resp_code  <= RC_LOCAL_REJECT;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              // Raw fields go out, so KEEP encodings reach the register untouched.
              bus_write <= 1'b1;
              bus_wdata <= {14'b0, req_shape, 10'b0, req_operation};
              cnt       <= '0;
              state     <= S_WR;
            end
          end
        end
        S_WR: begin
          if (bus_ready) begin
            bus_write <= 1'b0;
            bus_wdata <= '0;
            bus_read  <= 1'b1;
            cnt       <= '0;
            state     <= S_RD;
          end else if (timed_out) begin
            bus_write  <= 1'b0;
            bus_wdata  <= '0;
            resp_code  <= RC_ERROR;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD: begin
          if (bus_ready) begin
            bus_read     <= 1'b0;
            shadow_shape <= rb_shape;
            shadow_op    <= rb_op;
            resp_valid   <= 1'b1;
            state        <= S_RESP;
            if ({rb_shape, rb_op} == {eff_shape_q, eff_op_q})
              resp_code <= RC_OK;
            else if (({rb_shape, rb_op} == {old_shape, old_op}) &&
                     ({old_shape, old_op} != {eff_shape_q, eff_op_q}))
              resp_code <= RC_HW_REJECT;
            else
              resp_code <= RC_ERROR;
          end else if (timed_out) begin
            bus_read   <= 1'b0;
            resp_code  <= RC_ERROR;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_processor_ctrl_writer.sv
// Directed bench for shape_processor_ctrl_writer: init read, OK/KEEP paths, local and HW rejects,
// errors, write timeout and reset in the middle of a readback.
module tb_shape_processor_ctrl_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_shape;
  logic [5:0]  req_operation;
  logic        bus_write, bus_read, bus_ready;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_code, cur_shape;
  logic [5:0]  cur_operation;

  logic        wr_rdy_en, rd_rdy_en;
  int          rd_cnt, wr_cnt, wr_hi, both_cnt;
  logic [31:0] last_wdata;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Bus slave: completes an access in the cycle it is requested when enabled.
  assign bus_ready = (bus_write & wr_rdy_en) | (bus_read & rd_rdy_en);

  shape_processor_ctrl_writer #(.ADDR_W(8), .CTRL_ADDR(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_shape(req_shape), .req_operation(req_operation),
    .bus_write(bus_write), .bus_read(bus_read), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code),
    .cur_shape(cur_shape), .cur_operation(cur_operation)
  );

  always @(posedge clk) begin
    if (bus_read && bus_ready) rd_cnt++;
    if (bus_write && bus_ready) begin
      wr_cnt++;
      last_wdata = bus_wdata;
    end
    if (bus_write) wr_hi++;
    if (bus_write && bus_read) both_cnt++;
  end

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; wr_hi = 0; last_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({req_ready, bus_write, bus_read, bus_wdata, resp_valid, resp_code, cur_shape, cur_operation} !== '0) begin
      n_err++;
      $display("FAIL %s_outputs: got rr=%b wr=%b rd=%b wd=%h rv=%b rc=%0d cur=%b/%h, want all zero",
               tag, req_ready, bus_write, bus_read, bus_wdata, resp_valid, resp_code, cur_shape, cur_operation);
    end
  endtask

  task automatic wait_req_ready(input string tag);
    int k = 0;
    while (!req_ready && k < 60) begin @(negedge clk); k++; end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_req_ready: got %b after %0d cycles, want 1", tag, req_ready, k);
    end
  endtask

  task automatic do_req(input string tag, input logic [1:0] s, input logic [5:0] o,
                        input logic [31:0] rdata, input logic [1:0] exp_code, input int exp_lat,
                        input logic [31:0] exp_wdata, input int exp_wr, input int exp_rd,
                        input logic [1:0] exp_s, input logic [5:0] exp_o);
    int lat;
    wait_req_ready(tag);
    bus_rdata = rdata;
    clear_counts();
    req_valid = 1'b1; req_shape = s; req_operation = o;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
    n_vec++;
    if (resp_valid !== 1'b1 || lat != exp_lat) begin
      n_err++;
      $display("FAIL %s_latency: got resp_valid=%b at %0d cycles, want 1 at %0d", tag, resp_valid, lat, exp_lat);
    end
    n_vec++;
    if (resp_code !== exp_code) begin
      n_err++;
      $display("FAIL %s_code: got %0d want %0d", tag, resp_code, exp_code);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_handshake: got req_ready=%b resp_valid=%b want 1/0", tag, req_ready, resp_valid);
    end
    n_vec++;
    if (wr_cnt != exp_wr || rd_cnt != exp_rd) begin
      n_err++;
      $display("FAIL %s_bus_count: got wr=%0d rd=%0d want wr=%0d rd=%0d", tag, wr_cnt, rd_cnt, exp_wr, exp_rd);
    end
    if (exp_wr != 0) begin
      n_vec++;
      if (last_wdata !== exp_wdata) begin
        n_err++;
        $display("FAIL %s_wdata: got %h want %h", tag, last_wdata, exp_wdata);
      end
    end
    n_vec++;
    if (cur_shape !== exp_s || cur_operation !== exp_o) begin
      n_err++;
      $display("FAIL %s_shadow: got %b/%h want %b/%h", tag, cur_shape, cur_operation, exp_s, exp_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
  endtask

  task automatic test_init();
    bus_rdata = 32'h0001_0001;
    clear_counts();
    rst_n = 1'b1;
    @(negedge clk);
    wait_req_ready("init");
    n_vec++;
    if (cur_shape !== 2'b01 || cur_operation !== 6'h01) begin
      n_err++;
      $display("FAIL init_shadow: got %b/%h want 01/01", cur_shape, cur_operation);
    end
    n_vec++;
    if (rd_cnt != 1 || wr_cnt != 0) begin
      n_err++;
      $display("FAIL init_bus_count: got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt, wr_cnt);
    end
    n_vec++;
    if (bus_addr !== 8'h00) begin
      n_err++;
      $display("FAIL init_addr: got %h want 00", bus_addr);
    end
  endtask

  task automatic test_ok_paths();
    do_req("ok_10_20", 2'b10, 6'h20, 32'h0002_0020, 2'd0, 3, 32'h0002_0020, 1, 1, 2'b10, 6'h20);
    do_req("restore_a", 2'b01, 6'h01, 32'h0001_0001, 2'd0, 3, 32'h0001_0001, 1, 1, 2'b01, 6'h01);
    do_req("keep_shape", 2'b11, 6'h10, 32'h0001_0010, 2'd0, 3, 32'h0003_0010, 1, 1, 2'b01, 6'h10);
    do_req("restore_b", 2'b01, 6'h01, 32'h0001_0001, 2'd0, 3, 32'h0001_0001, 1, 1, 2'b01, 6'h01);
    do_req("keep_both", 2'b11, 6'h3F, 32'h0001_0001, 2'd0, 3, 32'h0003_003F, 1, 1, 2'b01, 6'h01);
  endtask

  task automatic test_local_reject();
    do_req("rej_pair", 2'b10, 6'h10, 32'hFFFF_FFFF, 2'd1, 1, 32'h0, 0, 0, 2'b01, 6'h01);
    do_req("rej_op05", 2'b01, 6'h05, 32'hFFFF_FFFF, 2'd1, 1, 32'h0, 0, 0, 2'b01, 6'h01);
    do_req("rej_shape00", 2'b00, 6'h00, 32'hFFFF_FFFF, 2'd1, 1, 32'h0, 0, 0, 2'b01, 6'h01);
    do_req("rej_op21_rect", 2'b01, 6'h21, 32'hFFFF_FFFF, 2'd1, 1, 32'h0, 0, 0, 2'b01, 6'h01);
  endtask

  task automatic test_hw_outcomes();
    do_req("hw_reject", 2'b10, 6'h00, 32'h0001_0001, 2'd2, 3, 32'h0002_0000, 1, 1, 2'b01, 6'h01);
    do_req("rb_error", 2'b10, 6'h00, 32'h0002_0001, 2'd3, 3, 32'h0002_0000, 1, 1, 2'b10, 6'h01);
    do_req("restore_c", 2'b01, 6'h01, 32'h0001_0001, 2'd0, 3, 32'h0001_0001, 1, 1, 2'b01, 6'h01);
  endtask

  task automatic test_timeout();
    wr_rdy_en = 1'b0;
    do_req("wr_timeout", 2'b10, 6'h00, 32'h0002_0000, 2'd3, 17, 32'h0, 0, 0, 2'b01, 6'h01);
    n_vec++;
    if (wr_hi != 16) begin
      n_err++;
      $display("FAIL wr_timeout_width: bus_write high %0d cycles, want 16", wr_hi);
    end
    wr_rdy_en = 1'b1;
  endtask

  task automatic test_reset_mid_rd();
    wait_req_ready("mid_rd");
    rd_rdy_en = 1'b0;
    req_valid = 1'b1; req_shape = 2'b10; req_operation = 6'h00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_read !== 1'b1 || bus_write !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rd_in_read: got rd=%b wr=%b want 1/0", bus_read, bus_write);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rd_reset");
    rd_rdy_en = 1'b1;
    bus_rdata = 32'h0001_0001;
    @(negedge clk);
    clear_counts();
    rst_n = 1'b1;
    @(negedge clk);
    wait_req_ready("mid_rd_reinit");
    n_vec++;
    if (rd_cnt != 1 || wr_cnt != 0 || cur_shape !== 2'b01 || cur_operation !== 6'h01) begin
      n_err++;
      $display("FAIL mid_rd_reinit: got rd=%0d wr=%0d cur=%b/%h want 1/0 01/01",
               rd_cnt, wr_cnt, cur_shape, cur_operation);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_shape = '0; req_operation = '0;
    resp_ready = 1'b0; bus_rdata = '0;
    wr_rdy_en = 1'b1; rd_rdy_en = 1'b1;
    both_cnt = 0;
    clear_counts();
    test_reset();
    test_init();
    test_ok_paths();
    test_local_reject();
    test_hw_outcomes();
    test_timeout();
    test_reset_mid_rd();
    n_vec++;
    if (both_cnt != 0) begin
      n_err++;
      $display("FAIL write_read_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shape_processor_ctrl_writer.md
Name: shape_processor_ctrl_writer

Overview:
- Bus-side initiator that programs the shape processor CTRL SFR: SHAPE at bits [17:16], OPERATION at bits [5:0], all other bits reserved.
- Accepts shape/operation requests over valid/ready and resolves KEEP fields against a local shadow of CTRL.
- Pre-checks each request for encoding and combination legality, issues the bus write, then reads CTRL back to classify the outcome.
- Sits between the firmware-facing command path and the SFR bus, and is the writing end of the CTRL register protocol.

Parameters:
- ADDR_W, 8, bus address width.
- CTRL_ADDR, 8'h00, address of the CTRL SFR.
- TIMEOUT, 16, max cycles to wait for bus_ready per bus access; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_shape  in  2  requested SHAPE (2'b11 = KEEP)
- req_operation  in  6  requested OPERATION (6'h3F = KEEP)
- bus_write  out  1  write request
- bus_read  out  1  read request
- bus_addr  out  ADDR_W  always CTRL_ADDR
- bus_wdata  out  32  write data
- bus_ready  in  1  access completes this cycle
- bus_rdata  in  32  read data, valid when bus_read && bus_ready
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_code  out  2  0 OK, 1 LOCAL_REJECT, 2 HW_REJECT, 3 ERROR
- cur_shape  out  2  shadow SHAPE
- cur_operation  out  6  shadow OPERATION

Behaviour:
- Reset values: req_ready 0, bus_write 0, bus_read 0, bus_wdata 0, resp_valid 0, resp_code 0, shadow 0. Reset takes effect immediately at any point, including mid-access; all outputs return to reset values.
- FSM states: INIT, IDLE, WR, RD, RESP. Reset enters INIT.
- INIT:
  - Drive bus_read until bus_ready.
  - Load shadow from bus_rdata[17:16] and bus_rdata[5:0], then go to IDLE. No response is generated.
  - On timeout, shadow keeps its reset value 0, then go to IDLE.
- IDLE:
  - req_ready = 1 combinationally. A request is accepted when req_valid && req_ready.
  - Resolution: eff_shape = (req_shape == 2'b11) ? shadow shape : req_shape. eff_op = (req_operation == 6'h3F) ? shadow op : req_operation.
  - LOCAL_REJECT conditions:
    - raw req_shape is 2'b00;
    - raw req_operation is not in {00,01,10,20,21,3F} (hex);
    - eff pair is illegal.
  - Legal pairs: op 00/01 with shape 01 or 10; op 10 with shape 01 only; op 20/21 with shape 10 only. Anything involving shadow shape 00 or 11 is illegal.
  - On LOCAL_REJECT: no bus access; go to RESP with code 1 on the next cycle.
  - Otherwise latch old = shadow and go to WR.
- WR:
  - bus_write = 1 and bus_wdata = {14'b0, req_shape, 10'b0, req_operation}. Raw fields are written, so KEEP encodings reach the register unchanged; reserved bits are 0.
  - Signals are held stable until bus_ready, then go to RD. bus_write and bus_read are never asserted together.
- RD:
  - bus_read = 1 until bus_ready.
  - Shadow ← readback fields, always, whatever the outcome.
  - Classification:
    - readback == {eff_shape, eff_op} → OK (0);
    - readback == old and old ≠ eff → HW_REJECT (2);
    - otherwise → ERROR (3).
  - Go to RESP.
- Timeout:
  - A per-access counter is cleared on entry to WR/RD/INIT.
  - If bus_ready has not been seen after TIMEOUT cycles, deassert the request, leave the shadow unchanged and go to RESP with ERROR. In INIT, go to IDLE instead.
- RESP: resp_valid held with a stable code until resp_ready; then go to IDLE. With resp_valid && resp_ready, req_ready rises the following cycle. req_ready is never high outside IDLE.
- Latency, with bus_ready returned the cycle a request is raised: accept → WR (1 cycle) → RD (1 cycle) → resp_valid, i.e. 3 cycles after acceptance. LOCAL_REJECT responds 1 cycle after acceptance.

Test Plan:
- INIT read returns 0x0001_0001 → cur_shape = 01, cur_operation = 01, req_ready rises; exactly one read and no writes issued.
- Shadow RECT/AREA; request shape 10, op 20, readback 0x0002_0020 → wdata 0x0002_0020, resp_code 0, cur = 10/20.
- Shadow RECT/AREA; request shape 11 (KEEP), op 10 → wdata 0x0003_0010; readback 0x0001_0010 → OK.
- Shadow RECT/AREA; request shape 10, op 10 → LOCAL_REJECT one cycle after acceptance, no bus activity. Request op 0x05 → LOCAL_REJECT.
- Legal request 10/00 but readback 0x0001_0001 (unchanged) → HW_REJECT, shadow stays 01/01. Readback 0x0002_0001 → ERROR, shadow = 10/01.
- bus_ready never asserted in WR → ERROR after 16 cycles, bus_write drops, shadow unchanged. rst_n pulsed mid-RD → outputs go to reset values immediately and INIT read reissues.
